// File: rtl/forwarding_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_hazard_unit_if
//  Description : Decode/ALU/MEM-stage hazard signals bundled between the
//                pipeline (master) and the forwarding/hazard unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface forwarding_hazard_unit_if #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
);
   logic [NUM_SRC*ADDR_W-1:0] rs_addr_id;
   logic [NUM_SRC-1:0]        rs_valid_id;
   logic [ADDR_W-1:0]         ex_rd_addr;
   logic                      ex_reg_write;
   logic                      ex_mem_read;
   logic [ADDR_W-1:0]         mem_rd_addr;
   logic                      mem_reg_write;
   logic                      freeze;
   logic                      flush;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall;
   logic                      ex_bubble;
   logic [CNT_W-1:0]          stall_count;

   // Pipeline side: drives stage information, consumes hazard decisions.
   modport master (
      output rs_addr_id, rs_valid_id, ex_rd_addr, ex_reg_write, ex_mem_read,
             mem_rd_addr, mem_reg_write, freeze, flush,
      input  fwd_sel, stall, ex_bubble, stall_count
   );

   // Hazard unit side.
   modport slave (
      input  rs_addr_id, rs_valid_id, ex_rd_addr, ex_reg_write, ex_mem_read,
             mem_rd_addr, mem_reg_write, freeze, flush,
      output fwd_sel, stall, ex_bubble, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_hazard_unit
//  Description : Operand forwarding select generation and load-use stall
//                control for a 5-stage pipeline, with a saturating count of
//                stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarding_hazard_unit #(
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  wire logic               clk,
   input  wire logic               reset,
   forwarding_hazard_unit_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   // Counter preload on entering STALL: the IDLE cycle already accounts for
   // one stall cycle and the STALL state exits after the counter reaches 0.
   localparam logic [3:0] c_cnt_reload = 4'(LOAD_LAT - 2);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2*NUM_SRC-1:0]  fwd_sel_q, fwd_sel_d;
   logic [CNT_W-1:0]      stall_count_q, stall_count_d;

   logic [NUM_SRC-1:0]    w_ex_match;
   logic [NUM_SRC-1:0]    w_mem_match;
   logic [2*NUM_SRC-1:0]  w_sel;
   logic                  w_load_use;
   logic                  w_stall;

   // Per-source match against ALU and MEM destinations; ALU stage wins.
   always_comb begin
      w_ex_match  = '0;
      w_mem_match = '0;
      w_sel       = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_ex_match[k]  = bus.rs_valid_id[k] && bus.ex_reg_write &&
                          (bus.ex_rd_addr != '0) &&
                          (bus.ex_rd_addr == bus.rs_addr_id[k*ADDR_W +: ADDR_W]);
         w_mem_match[k] = bus.rs_valid_id[k] && bus.mem_reg_write &&
                          (bus.mem_rd_addr != '0) &&
                          (bus.mem_rd_addr == bus.rs_addr_id[k*ADDR_W +: ADDR_W]);
         if (w_ex_match[k])
            w_sel[2*k +: 2] = 2'b01;
         else if (w_mem_match[k])
            w_sel[2*k +: 2] = 2'b10;
         else
            w_sel[2*k +: 2] = 2'b00;
      end
      w_load_use = bus.ex_mem_read && (|w_ex_match);
   end

   // Stall FSM next state and combinational stall; flush and freeze mask it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_stall = 1'b0;
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else if (!reset && !bus.freeze) begin
         case (state_q)
            IDLE: begin
               if (w_load_use) begin
                  w_stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = STALL;
                     cnt_d   = c_cnt_reload;
                  end
               end
            end
            STALL: begin
               w_stall = 1'b1;
               if (cnt_q == 4'd0)
                  state_d = IDLE;
               else
                  cnt_d = cnt_q - 4'd1;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // Forwarding select and saturating stall statistics next values.
   always_comb begin
      fwd_sel_d     = fwd_sel_q;
      stall_count_d = stall_count_q;
      if (bus.flush)
         fwd_sel_d = '0;
      else if (!bus.freeze)
         fwd_sel_d = w_stall ? '0 : w_sel;
      if (w_stall && (stall_count_q != {CNT_W{1'b1}}))
         stall_count_d = stall_count_q + 1'b1;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         fwd_sel_q     <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fwd_sel_q     <= fwd_sel_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.fwd_sel     = fwd_sel_q;
   assign bus.stall       = w_stall;
   assign bus.ex_bubble   = w_stall;
   assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forwarding_hazard_unit
//  Description : Two hazard units (A: LOAD_LAT=1, CNT_W=2; B: LOAD_LAT=3,
//                CNT_W=16) share one stimulus stream and are compared against
//                a remaining-stall-cycles reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] rs_addr;
   logic [1:0] rs_valid;
   logic [4:0] ex_rd, mem_rd;
   logic       ex_w, ex_mr, mem_w, frz, fl;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state per instance (0 = A, 1 = B).
   int         rem   [2];
   int         cnt_m [2];
   logic [3:0] fwd_m [2];
   int         lat   [2];
   int         cmax  [2];

   always #5 clk = ~clk;

   forwarding_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2), .CNT_W(2))  ifa ();
   forwarding_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) ifb ();

   assign ifa.rs_addr_id = rs_addr;   assign ifb.rs_addr_id = rs_addr;
   assign ifa.rs_valid_id = rs_valid; assign ifb.rs_valid_id = rs_valid;
   assign ifa.ex_rd_addr = ex_rd;     assign ifb.ex_rd_addr = ex_rd;
   assign ifa.ex_reg_write = ex_w;    assign ifb.ex_reg_write = ex_w;
   assign ifa.ex_mem_read = ex_mr;    assign ifb.ex_mem_read = ex_mr;
   assign ifa.mem_rd_addr = mem_rd;   assign ifb.mem_rd_addr = mem_rd;
   assign ifa.mem_reg_write = mem_w;  assign ifb.mem_reg_write = mem_w;
   assign ifa.freeze = frz;           assign ifb.freeze = frz;
   assign ifa.flush = fl;             assign ifb.flush = fl;

   forwarding_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(2)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   forwarding_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_sel();
      logic [3:0] s = 4'b0;
      for (int k = 0; k < 2; k++) begin
         int a = int'(rs_addr[k*5 +: 5]);
         bit e = rs_valid[k] && ex_w  && ex_rd  != 0 && int'(ex_rd)  == a;
         bit m = rs_valid[k] && mem_w && mem_rd != 0 && int'(mem_rd) == a;
         s[2*k +: 2] = e ? 2'b01 : (m ? 2'b10 : 2'b00);
      end
      return s;
   endfunction

   function automatic bit ref_lu();
      bit lu = 0;
      for (int k = 0; k < 2; k++)
         if (rs_valid[k] && ex_w && ex_rd != 0 && ex_rd == rs_addr[k*5 +: 5]) lu = 1;
      return lu && ex_mr;
   endfunction

   function automatic bit exp_stall(int i);
      if (reset || frz || fl) return 0;
      return (rem[i] > 0) || ref_lu();
   endfunction

   task automatic model_zero();
      for (int i = 0; i < 2; i++) begin
         rem[i] = 0; cnt_m[i] = 0; fwd_m[i] = 4'b0;
      end
   endtask

   task automatic model_edge(int i, bit st);
      if (reset) begin
         rem[i] = 0; cnt_m[i] = 0; fwd_m[i] = 4'b0;
      end else if (fl) begin
         rem[i] = 0; fwd_m[i] = 4'b0;
      end else if (!frz) begin
         if (st && cnt_m[i] < cmax[i]) cnt_m[i]++;
         if (rem[i] > 0) rem[i]--;
         else if (ref_lu()) rem[i] = lat[i] - 1;
         fwd_m[i] = st ? 4'b0 : ref_sel();
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, "/A/stall"},  32'(ifa.stall),       32'(exp_stall(0)));
      chk({where, "/A/bubble"}, 32'(ifa.ex_bubble),   32'(exp_stall(0)));
      chk({where, "/A/fwd"},    32'(ifa.fwd_sel),     32'(fwd_m[0]));
      chk({where, "/A/count"},  32'(ifa.stall_count), cnt_m[0]);
      chk({where, "/B/stall"},  32'(ifb.stall),       32'(exp_stall(1)));
      chk({where, "/B/bubble"}, 32'(ifb.ex_bubble),   32'(exp_stall(1)));
      chk({where, "/B/fwd"},    32'(ifb.fwd_sel),     32'(fwd_m[1]));
      chk({where, "/B/count"},  32'(ifb.stall_count), cnt_m[1]);
   endtask

   // One clock: check mid-cycle, then advance the model across the edge.
   task automatic cycle(input string where);
      bit s0, s1;
      @(negedge clk);
      if (reset) model_zero();
      check_all(where);
      s0 = exp_stall(0);
      s1 = exp_stall(1);
      @(posedge clk);
      model_edge(0, s0);
      model_edge(1, s1);
      #1;
   endtask

   task automatic set_in(input int r1, input int r2, input int v, input int exr, input int exw,
                         input int exm, input int mr, input int mw, input int fz, input int f);
      rs_addr  = {5'(r2), 5'(r1)};
      rs_valid = 2'(v);
      ex_rd    = 5'(exr); ex_w  = 1'(exw); ex_mr = 1'(exm);
      mem_rd   = 5'(mr);  mem_w = 1'(mw);
      frz      = 1'(fz);  fl    = 1'(f);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      lat[0] = 1; lat[1] = 3; cmax[0] = 3; cmax[1] = 65535;
      model_zero();
      // Reset held with a load-use pattern present: outputs must stay 0.
      reset = 1'b1;
      set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
      #3;
      check_all("reset_init");
      cycle("reset_hold");
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("idle");

      // Forward rs1 from MEM, rs2 from WB.
      set_in(5, 7, 3, 5, 1, 0, 7, 1, 0, 0);
      cycle("fwd_mix");
      chk("req038/A", 32'(ifa.fwd_sel), 32'h9);
      chk("req038/B", 32'(ifb.fwd_sel), 32'h9);

      // ALU-stage priority, then address 0 never forwards.
      set_in(3, 0, 1, 3, 1, 0, 3, 1, 0, 0);
      cycle("prio");
      chk("req039_prio", 32'(ifa.fwd_sel[1:0]), 32'h1);
      set_in(0, 0, 3, 0, 1, 0, 0, 1, 0, 0);
      cycle("addr0");
      chk("req039_zero", 32'(ifa.fwd_sel), 32'h0);

      // Load-use, then the loaded value forwarded from WB.
      set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
      cycle("lu");
      chk("req040_fwd0", 32'(ifa.fwd_sel), 32'h0);
      set_in(9, 0, 1, 0, 0, 0, 9, 1, 0, 0);
      cycle("lu_wb");
      chk("req040_wb", 32'(ifa.fwd_sel[1:0]), 32'h2);
      chk("req040_cnt", 32'(ifa.stall_count), 32'h1);
      cycle("lu_wb2");
      chk("lat3_cnt", 32'(ifb.stall_count), 32'h3);

      // Freeze for two cycles in the middle of a 3-cycle stall.
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("clr");
      set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
      cycle("frz_lu");
      frz = 1'b1;
      cycle("frz1");
      cycle("frz2");
      frz = 1'b0;
      cycle("frz_s2");
      cycle("frz_s3");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("frz_done");
      chk("req041_cnt", 32'(ifb.stall_count), 32'd6);

      // Flush during the second stall cycle.
      set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
      cycle("fl_lu");
      fl = 1'b1;
      cycle("fl_s2");
      chk("req042_flush_fwd", 32'(ifb.fwd_sel), 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("fl_idle");

      // Asynchronous reset while in STALL.
      set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
      cycle("rst_lu");
      reset = 1'b1;
      #1;
      model_zero();
      check_all("req042_async_rst");
      cycle("rst_hold");
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("rst_rel");

      // Five separate load-use events: 2-bit counter saturates.
      for (int e = 0; e < 5; e++) begin
         set_in(9, 0, 1, 9, 1, 1, 0, 0, 0, 0);
         cycle("sat_lu");
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         cycle("sat_gap1");
         cycle("sat_gap2");
         cycle("sat_gap3");
      end
      chk("req043_sat", 32'(ifa.stall_count), 32'd3);
      chk("req043_B", 32'(ifb.stall_count), 32'd15);

      // Randomized traffic on small address space to provoke matches.
      for (int r = 0; r < 400; r++) begin
         reset    = ($urandom_range(0, 63) == 0);
         rs_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rs_valid = 2'($urandom_range(0, 3));
         ex_rd    = 5'($urandom_range(0, 7));
         ex_w     = 1'($urandom_range(0, 3) != 0);
         ex_mr    = 1'($urandom_range(0, 1));
         mem_rd   = 5'($urandom_range(0, 7));
         mem_w    = 1'($urandom_range(0, 3) != 0);
         frz      = ($urandom_range(0, 7) == 0);
         fl       = ($urandom_range(0, 15) == 0);
         if (reset) begin
            #1;
            model_zero();
         end
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
